// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Stores to TXDATA enqueue bytes. STATUS reports line and FIFO state, and a store
// to STATUS with bit 3 set clears the sticky overflow flag.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | line high; pops the FIFO head on the first non-empty cycle
//   START | start bit (tx=0) for CLKS_PER_BIT cycles
//   DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (tx=1) for CLKS_PER_BIT cycles
module uart_tx_mmio #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8,
   parameter int PTR_W        = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        WE,
   input  logic [2:0]  ADDR,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        tx,
   output logic        irq_empty
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [PTR_W:0] DEPTH_C   = FIFO_DEPTH[PTR_W:0];
   localparam logic [15:0]    BAUD_LAST = CLKS_PER_BIT[15:0] - 16'd1;

   state_t           state;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic [15:0]      baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;

   logic fifo_full;
   logic fifo_empty;
   logic pop;
   logic push;
   logic wr_txdata;
   logic wr_status;
   logic baud_done;
   logic unused_wd;

   assign fifo_full  = (count == DEPTH_C);
   assign fifo_empty = (count == '0);
   assign pop        = (state == IDLE) && !fifo_empty;
   assign wr_txdata  = sel && WE && (ADDR == 3'h0);
   assign wr_status  = sel && WE && (ADDR == 3'h4);
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign push       = wr_txdata && (!fifo_full || pop);
   assign baud_done  = (baud_cnt == BAUD_LAST);
   assign unused_wd  = ^WD[31:8];

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= WD[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (wr_txdata && fifo_full && !pop) overflow <= 1'b1;
         else if (wr_status && WD[3])        overflow <= 1'b0;
      end
   end

   // Serialiser FSM; tx is registered and driven from the state transitions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift_reg <= fifo_mem[rd_ptr];
                  baud_cnt  <= '0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   // Empty interrupt, one edge behind the FIFO and FSM state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq_empty <= 1'b1;
      else        irq_empty <= fifo_empty && (state == IDLE);
   end

   // Read mux: only STATUS returns data, everything else reads as zero.
   always_comb begin
      RD = '0;
      if (sel && (ADDR == 3'h4)) begin
         RD[0]             = (state != IDLE);
         RD[1]             = fifo_full;
         RD[2]             = fifo_empty;
         RD[3]             = overflow;
         RD[8 +: PTR_W+1]  = count;
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a short bit time and a serial line monitor.
module tb_uart_tx_mmio;
   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic        WE = 1'b0;
   logic [2:0]  ADDR = 3'h0;
   logic [31:0] WD = 32'h0;
   logic [31:0] RD;
   logic        tx;
   logic        irq_empty;

   int total = 0;
   int bad = 0;
   logic [7:0] rx_q[$];

   uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .reset(reset), .sel(sel), .WE(WE), .ADDR(ADDR), .WD(WD),
      .RD(RD), .tx(tx), .irq_empty(irq_empty)
   );

   always #5 clk = ~clk;

   // Line monitor: samples mid-bit after each falling edge; drops frames cut by reset.
   task automatic wait_clks(input int n, inout logic ok);
      repeat (n) begin
         @(posedge clk);
         if (reset !== 1'b1) ok = 1'b0;
      end
   endtask

   always begin
      logic       ok;
      logic [7:0] b;
      @(negedge tx);
      ok = (reset === 1'b1);
      b  = 8'h00;
      wait_clks(CPB/2, ok);
      for (int i = 0; i < 8; i++) begin
         wait_clks(CPB, ok);
         #1 b[i] = tx;
      end
      wait_clks(CPB, ok);
      if (ok) rx_q.push_back(b);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      sel = 1'b1; WE = 1'b1; ADDR = a; WD = d;
      @(negedge clk);
      sel = 1'b0; WE = 1'b0; ADDR = 3'h0; WD = 32'h0;
   endtask

   task automatic read_status(output logic [31:0] v);
      sel = 1'b1; WE = 1'b0; ADDR = 3'h4;
      #1 v = RD;
      sel = 1'b0; ADDR = 3'h0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (rx_q.size() < n) begin
         bad++;
         $display("FAIL rx_timeout: got %0d bytes want %0d", rx_q.size(), n);
      end
   endtask

   task automatic test_reset;
      logic [31:0] v;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sel = i[0]; WE = i[1]; ADDR = 3'h0; WD = 32'h55;
      end
      @(negedge clk);
      sel = 1'b0; WE = 1'b0;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL t1_tx_in_reset: got %b want 1", tx); end
      read_status(v);
      total++; if (v !== 32'h4) begin bad++; $display("FAIL t1_status_in_reset: got %h want 00000004", v); end
      total++; if (irq_empty !== 1'b1) begin bad++; $display("FAIL t1_irq_in_reset: got %b want 1", irq_empty); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL t1_tx_after: got %b want 1", tx); end
      read_status(v);
      total++; if (v !== 32'h4) begin bad++; $display("FAIL t1_status_after: got %h want 00000004", v); end
      total++; if (irq_empty !== 1'b1) begin bad++; $display("FAIL t1_irq_after: got %b want 1", irq_empty); end
   endtask

   task automatic test_single_byte;
      logic [31:0] v;
      logic [9:0]  frame;
      int          tx_bad = 0;
      int          busy_bad = 0;
      frame = 10'b1_1010_0101_0;
      rx_q.delete();
      @(negedge clk);
      do_write(3'h0, 32'hA5);
      read_status(v);
      total++; if (v !== 32'h100) begin bad++; $display("FAIL t2_status_queued: got %h want 00000100", v); end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL t2_tx_before_pop: got %b want 1", tx); end
      sel = 1'b1; ADDR = 3'h4;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (tx !== frame[i/4]) begin
            tx_bad++;
            $display("FAIL t2_tx[%0d]: got %b want %b", i, tx, frame[i/4]);
         end
         if (RD[0] !== 1'b1) busy_bad++;
         if (i == 20) begin
            total++; if (irq_empty !== 1'b0) begin bad++; $display("FAIL t2_irq_busy: got %b want 0", irq_empty); end
         end
      end
      total++; if (tx_bad != 0) bad++;
      total++; if (busy_bad != 0) begin bad++; $display("FAIL t2_busy: got %0d idle cycles want 0", busy_bad); end
      @(negedge clk);
      #1;
      total++; if (RD !== 32'h4) begin bad++; $display("FAIL t2_idle_at_41: got %h want 00000004", RD); end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL t2_tx_idle: got %b want 1", tx); end
      sel = 1'b0; ADDR = 3'h0;
      repeat (2) @(negedge clk);
      total++; if (irq_empty !== 1'b1) begin bad++; $display("FAIL t2_irq_idle: got %b want 1", irq_empty); end
      total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         bad++; $display("FAIL t2_rx: got %0d bytes first %h want 1 byte a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
      end
   endtask

   // Fill, overflow and clear; then the write in the pop cycle of the next frame.
   task automatic test_fill_and_simultaneous;
      logic [31:0] v;
      logic [7:0]  exp_b;
      rx_q.delete();
      @(negedge clk);
      for (int i = 1; i <= 9; i++) do_write(3'h0, 32'(i));
      read_status(v);
      total++; if (v !== 32'h803) begin bad++; $display("FAIL t3_full: got %h want 00000803", v); end
      do_write(3'h0, 32'h0A);
      read_status(v);
      total++; if (v !== 32'h80B) begin bad++; $display("FAIL t3_overflow: got %h want 0000080b", v); end
      do_write(3'h4, 32'h8);
      read_status(v);
      total++; if (v !== 32'h803) begin bad++; $display("FAIL t3_ovf_clear: got %h want 00000803", v); end
      repeat (30) @(negedge clk);
      read_status(v);
      total++; if (v[0] !== 1'b1) begin bad++; $display("FAIL t4_busy_in_stop: got %b want 1", v[0]); end
      @(negedge clk);
      read_status(v);
      total++; if (v !== 32'h802) begin bad++; $display("FAIL t4_idle_gap: got %h want 00000802", v); end
      do_write(3'h0, 32'h3C);
      read_status(v);
      total++; if (v !== 32'h803) begin bad++; $display("FAIL t4_simul_write: got %h want 00000803", v); end
      wait_rx(10, 1000);
      for (int i = 0; i < 10; i++) begin
         exp_b = (i < 9) ? 8'(i + 1) : 8'h3C;
         total++;
         if (i >= rx_q.size()) begin
            bad++; $display("FAIL t3_order[%0d]: got none want %h", i, exp_b);
         end else if (rx_q[i] !== exp_b) begin
            bad++; $display("FAIL t3_order[%0d]: got %h want %h", i, rx_q[i], exp_b);
         end
      end
      repeat (60) @(negedge clk);
      total++; if (rx_q.size() != 10) begin bad++; $display("FAIL t3_extra_bytes: got %0d want 10", rx_q.size()); end
      read_status(v);
      total++; if (v !== 32'h4) begin bad++; $display("FAIL t4_drained: got %h want 00000004", v); end
      total++; if (irq_empty !== 1'b1) begin bad++; $display("FAIL t4_irq: got %b want 1", irq_empty); end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] v;
      int          low_cnt = 0;
      rx_q.delete();
      @(negedge clk);
      do_write(3'h0, 32'h37);
      repeat (18) @(negedge clk);
      total++; if (tx !== 1'b0) begin bad++; $display("FAIL t5_bit3_low: got %b want 0", tx); end
      #2 reset = 1'b0;
      #1;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL t5_tx_abort: got %b want 1", tx); end
      read_status(v);
      total++; if (v !== 32'h4) begin bad++; $display("FAIL t5_status: got %h want 00000004", v); end
      total++; if (irq_empty !== 1'b1) begin bad++; $display("FAIL t5_irq: got %b want 1", irq_empty); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_cnt++;
      end
      total++; if (low_cnt != 0) begin bad++; $display("FAIL t5_no_resend: got %0d low cycles want 0", low_cnt); end
      total++; if (rx_q.size() != 0) begin bad++; $display("FAIL t5_rx_empty: got %0d bytes want 0", rx_q.size()); end
   endtask

   task automatic test_decode;
      logic [31:0] v;
      int          low_cnt = 0;
      @(negedge clk);
      sel = 1'b0; WE = 1'b1; ADDR = 3'h0; WD = 32'h77;
      @(negedge clk);
      WE = 1'b0; ADDR = 3'h4;
      #1;
      total++; if (RD !== 32'h0) begin bad++; $display("FAIL t6_rd_unselected: got %h want 00000000", RD); end
      @(negedge clk);
      do_write(3'h2, 32'h66);
      read_status(v);
      total++; if (v !== 32'h4) begin bad++; $display("FAIL t6_status: got %h want 00000004", v); end
      sel = 1'b1; ADDR = 3'h0;
      #1;
      total++; if (RD !== 32'h0) begin bad++; $display("FAIL t6_txdata_read: got %h want 00000000", RD); end
      sel = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_cnt++;
      end
      total++; if (low_cnt != 0) begin bad++; $display("FAIL t6_line_quiet: got %0d low cycles want 0", low_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_fill_and_simultaneous();
      test_reset_mid_frame();
      test_decode();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
